// File: rtl/alu_seq.sv
// alu_seq: registered ALU with binary ops completing in one cycle and an
// optional two-cycle BCD add/subtract. Flags and result hold until the next
// completion; DONE pulses for one cycle at each completion.
module alu_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          DEC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic             DEC,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Cin,
  output logic [WIDTH-1:0] RES,
  output logic             Cout,
  output logic             OVFout,
  output logic             Nout,
  output logic             Zout,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned WP1  = WIDTH + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_INV = 4'd9;

  typedef enum logic {IDLE, CALC} state_t;

  // Binary/logic/shift result packed as {carry, overflow, result}.
  function automatic logic [WIDTH+1:0] calc_bin(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] nb;
    logic             c;
    logic             v;
    sum = '0;
    r   = '0;
    c   = cin;
    v   = 1'b0;
    nb  = ~b;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + WP1'(cin);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, nb} + WP1'(cin);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_EOR: r = a ^ b;
      OP_OR:  r = a | b;
      OP_INV: r = ~a;
      OP_ASL: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      OP_LSR: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0];       end
      OP_ROL: begin r = {a[WIDTH-2:0], cin};  c = a[WIDTH-1]; end
      OP_ROR: begin r = {cin, a[WIDTH-1:1]};  c = a[0];       end
      default: ;
    endcase
    return {c, v, r};
  endfunction

  // Per-nibble decimal add/subtract packed as {carry, result}.
  function automatic logic [WIDTH:0] calc_dec(input logic sub,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic cin);
    logic [WIDTH-1:0] r;
    logic [3:0]       ai;
    logic [3:0]       bi;
    logic [4:0]       s;
    logic [4:0]       s10;
    logic [5:0]       d;
    logic [5:0]       d10;
    logic             cy;
    r  = '0;
    cy = sub ? ~cin : cin;
    for (int unsigned i = 0; i < NDIG; i++) begin
      ai  = a[4*i +: 4];
      bi  = b[4*i +: 4];
      s   = {1'b0, ai} + {1'b0, bi} + 5'(cy);
      s10 = s - 5'd10;
      d   = {2'b00, ai} - {2'b00, bi} - 6'(cy);
      d10 = d + 6'd10;
      if (sub) begin
        if (d[5]) begin
          r[4*i +: 4] = d10[3:0];
          cy          = 1'b1;
        end else begin
          r[4*i +: 4] = d[3:0];
          cy          = 1'b0;
        end
      end else begin
        if (s > 5'd9) begin
          r[4*i +: 4] = s10[3:0];
          cy          = 1'b1;
        end else begin
          r[4*i +: 4] = s[3:0];
          cy          = 1'b0;
        end
      end
    end
    return {(sub ? ~cy : cy), r};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, sub_q, sub_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH+1:0] bin_c;
  logic [WIDTH:0]   dec_c;
  logic             is_dec_c;

  assign bin_c    = calc_bin(OP, Ain, Bin, Cin);
  assign dec_c    = calc_dec(sub_q, a_q, b_q, cin_q);
  assign is_dec_c = DEC_EN && DEC && ((OP == OP_ADD) || (OP == OP_SUB));

  // State, operand capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: accept in IDLE, finish decimal ops in CALC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d   = Ain;
          b_d   = Bin;
          cin_d = Cin;
          sub_d = (OP == OP_SUB);
          ovf_d = bin_c[WIDTH];
          if (is_dec_c) begin
            state_d = CALC;
            busy_d  = 1'b1;
          end else begin
            res_d  = bin_c[WIDTH-1:0];
            c_d    = bin_c[WIDTH+1];
            v_d    = bin_c[WIDTH];
            n_d    = bin_c[WIDTH-1];
            z_d    = (bin_c[WIDTH-1:0] == '0);
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        res_d   = dec_c[WIDTH-1:0];
        c_d     = dec_c[WIDTH];
        v_d     = ovf_q;
        n_d     = dec_c[WIDTH-1];
        z_d     = (dec_c[WIDTH-1:0] == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign RES    = res_q;
  assign Cout   = c_q;
  assign OVFout = v_q;
  assign Nout   = n_q;
  assign Zout   = z_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 8-bit datapath ALU. Takes a start pulse with operands and a 4-bit opcode, and produces a registered result with C/V/N/Z flags and a one-cycle done pulse. WIDTH is generic. Adds binary subtract and, when enabled, a two-cycle BCD (decimal-mode) add/subtract for the CPU core. Sits between the register file / operand latches and the status-register update logic.

## Interface
- WIDTH, 8, operand/result width in bits; ≥4; must be a multiple of 4 when DEC_EN=1
- DEC_EN, 1, 1 = decimal mode implemented; 0 = DEC input ignored
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- START  in  1  request; accepted when high and BUSY=0
- OP  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 EOR, 4 OR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 INV, 10-15 reserved
- DEC  in  1  decimal mode for ADD/SUB
- Ain  in  WIDTH  operand A
- Bin  in  WIDTH  operand B
- Cin  in  1  carry in (for SUB, 1 = no borrow)
- RES  out  WIDTH  registered result
- Cout  out  1  carry out (for SUB, 1 = no borrow)
- OVFout  out  1  signed overflow
- Nout  out  1  RES[WIDTH-1]
- Zout  out  1  RES == 0
- BUSY  out  1  operation in progress, START ignored
- DONE  out  1  one-cycle pulse; outputs valid from this cycle on

## Operation
- On accepted START, capture Ain, Bin, Cin, OP and DEC.
- A decimal op (ADD/SUB with DEC=1 and DEC_EN=1) uses FSM IDLE -> CALC -> IDLE.
- Every other op goes IDLE -> IDLE and completes at once.
- RES and all flags hold their value until the next completion.
- ADD, binary: {Cout,RES} = A + B + Cin.
  - OVFout = A[msb]==B[msb] && RES[msb]!=A[msb].
- SUB, binary: {Cout,RES} = A + ~B + Cin.
  - OVFout = A[msb]!=B[msb] && RES[msb]!=A[msb].
- ADD, decimal: processed per nibble i, LSB first, with c0 = Cin.
  - s = a_i + b_i + c_i (5-bit).
  - If s > 9: digit = (s-10)[3:0] and c_{i+1} = 1; otherwise digit = s and c_{i+1} = 0.
  - Cout = final carry.
- SUB, decimal: processed per nibble with borrow b0 = ~Cin.
  - d = a_i - b_i - b_i_borrow.
  - If d < 0: digit = (d+10)[3:0] and borrow_{i+1} = 1; otherwise borrow_{i+1} = 0.
  - Cout = ~final borrow.
- Decimal ops: OVFout is taken from the binary ADD/SUB result computed in cycle 1. N and Z come from the decimal RES.
- Non-BCD digits (>9) follow the formulas above, mod 16; no error is flagged.
- AND/EOR/OR: bitwise; Cout = Cin, OVFout = 0.
- INV: RES = ~A; Cout = Cin, OVFout = 0.
- ASL: RES = {A[W-2:0],0}, Cout = A[W-1].
- LSR: RES = {0,A[W-1:1]}, Cout = A[0].
- ROL: RES = {A[W-2:0],Cin}, Cout = A[W-1].
- ROR: RES = {Cin,A[W-1:1]}, Cout = A[0].
- Shifts and rotates: OVFout = 0. Bin is ignored.
- Reserved opcodes: RES = 0, Cout = Cin, OVFout = 0, Zout = 1, Nout = 0.
- DEC is ignored for every op other than ADD/SUB.

## Timing
- Reset values: RES = 0, Cout = 0, OVFout = 0, Nout = 0, Zout = 0, BUSY = 0, DONE = 0; FSM = IDLE.
- Single-cycle ops:
  - START sampled high at edge k.
  - Results and DONE = 1 are visible after edge k. DONE clears after edge k+1 unless a new START completes there.
  - BUSY stays 0, so START may be asserted every cycle for back-to-back operations.
- Decimal ops:
  - START at edge k gives BUSY = 1 after edge k.
  - Results, DONE = 1 and BUSY = 0 appear after edge k+1 (latency 2).
- START while BUSY = 1 is ignored: no capture, no extra DONE.
- START with DEC=1 but DEC_EN=0 follows the binary 1-cycle path.
- rst asserted mid-operation: all outputs take their reset values at once and the in-flight op is discarded. No DONE follows reset release.
- Ain/Bin/Cin/OP/DEC may change freely after the accepting edge.

## Test plan
- WIDTH=8, Ain=0xAA, Cin=1, START with ASL, LSR, ROL, ROR on consecutive cycles. Required results, one DONE per cycle, BUSY never high:
  - ASL: RES=0x54, C=1.
  - LSR: RES=0x55, C=0.
  - ROL: RES=0x55, C=1.
  - ROR: RES=0xD5, C=0, N=1.
- Binary ADD 0x7F+0x01, Cin=0 -> RES=0x80, C=0, V=1, N=1, Z=0; DONE one cycle after START.
- Decimal ADD 0x58+0x46, Cin=0 -> BUSY for 1 cycle, then RES=0x04, C=1, Z=0.
- Decimal SUB 0x12-0x21, Cin=1 -> RES=0x91, C=0, N=1.
- START asserted during a decimal op's BUSY cycle -> ignored; exactly one DONE, and RES matches the first op.
- WIDTH=16: ADD 0xFFFF+0x0001 -> RES=0x0000, C=1, Z=1.
- Reset mid-decimal-op -> RES=0, flags 0, BUSY=0, and no DONE after release.
